// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared types for the programmable slow-clock generator.
package clkdiv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } clkdiv_state_t;

    typedef enum logic [1:0] {
        MODE_RUN  = 2'b00,
        MODE_HALT = 2'b01,
        MODE_STEP = 2'b10
    } mode_t;

    // HALT and the unused encoding 2'b11 both park the clock.
    function automatic logic mode_is_halt(input logic [1:0] m);
        return (m == MODE_HALT) || (m == 2'b11);
    endfunction

endpackage

// File: rtl/clkdiv_edge_det.sv
// clkdiv_edge_det: rising-edge detector for the step push button.
// With CLKDIV_STEP_SYNC_EN defined, the input first passes through a
// two-flop synchroniser; otherwise it must already be fastclk-synchronous.
module clkdiv_edge_det
    import clkdiv_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o
);

    logic d_s;
    logic prev_q;

`ifdef CLKDIV_STEP_SYNC_EN
    logic sync1_q, sync2_q;

    // Two-flop synchroniser for an asynchronous button input.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
        end
    end

    assign d_s = sync2_q;
`else
    assign d_s = d_i;
`endif

    // Previous sample, refreshed every cycle so stale edges never queue up.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) prev_q <= 1'b0;
        else         prev_q <= d_s;
    end

    assign rise_o = d_s & ~prev_q;

endmodule

// File: rtl/clkdiv_prog.sv
// clkdiv_prog: runtime-programmable clock divider with RUN/HALT/STEP modes.
// Optional macro CLKDIV_STEP_SYNC_EN adds a step-input synchroniser.
module clkdiv_prog
    import clkdiv_pkg::*;
#(
    parameter int          W       = 20,
    parameter logic [W-1:0] RST_DIV = W'(1) << (W - 1)
) (
    input  logic         fastclk,
    input  logic         nreset,
    input  logic [W-1:0] div,
    input  logic [1:0]   mode,
    input  logic         step,
    output logic         clk,
    output logic         tick,
    output logic         halted
);

    clkdiv_state_t state_q;
    logic [W-1:0]  cnt_q;
    logic [W-1:0]  div_q;
    logic          clk_q, tick_q, halted_q;

    logic          step_rise;
    logic          phase_end;
    logic          go_high_d, go_low_d, go_idle_d;
    logic [W-1:0]  div_eff;

    clkdiv_edge_det u_step_det (
        .clk_i  (fastclk),
        .rst_ni (nreset),
        .d_i    (step),
        .rise_o (step_rise)
    );

    assign phase_end = (cnt_q == div_q - 1'b1);
    assign div_eff   = (div == '0) ? W'(1) : div;

    // Transition decode; a high phase is only ever left at its natural end.
    always_comb begin
        go_high_d = 1'b0;
        go_low_d  = 1'b0;
        go_idle_d = 1'b0;
        case (state_q)
            IDLE: go_high_d = (mode == MODE_RUN) ||
                              ((mode == MODE_STEP) && step_rise);
            HIGH: go_low_d  = phase_end;
            LOW: begin
                if (mode_is_halt(mode))  go_idle_d = 1'b1;
                else if (phase_end) begin
                    if (mode == MODE_RUN) go_high_d = 1'b1;
                    else                  go_idle_d = 1'b1;
                end
            end
            default: go_idle_d = 1'b1;
        endcase
    end

    // State, phase counter and registered outputs; divisor latched per period.
    always_ff @(posedge fastclk) begin
        if (!nreset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            div_q    <= RST_DIV;
            clk_q    <= 1'b0;
            tick_q   <= 1'b0;
            halted_q <= 1'b1;
        end else begin
            tick_q <= 1'b0;
            if (go_high_d) begin
                state_q  <= HIGH;
                div_q    <= div_eff;
                cnt_q    <= '0;
                clk_q    <= 1'b1;
                tick_q   <= 1'b1;
                halted_q <= 1'b0;
            end else if (go_low_d) begin
                state_q  <= LOW;
                cnt_q    <= '0;
                clk_q    <= 1'b0;
            end else if (go_idle_d) begin
                state_q  <= IDLE;
                cnt_q    <= '0;
                clk_q    <= 1'b0;
                halted_q <= 1'b1;
            end else if (state_q != IDLE) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign clk    = clk_q;
    assign tick   = tick_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_clkdiv_prog.sv
// tb_clkdiv_prog: directed + randomized checks of clkdiv_prog against a
// countdown-based behavioural model of the clock generator.
module tb_clkdiv_prog;

    localparam int W = 20;
`ifdef CLKDIV_STEP_SYNC_EN
    localparam int DLY = 2;
`else
    localparam int DLY = 0;
`endif

    logic         fastclk = 1'b0;
    logic         nreset  = 1'b0;
    logic [W-1:0] div     = W'(3);
    logic [1:0]   mode    = 2'b00;
    logic         step    = 1'b0;
    logic         clk, tick, halted;

    int checks = 0;
    int errors = 0;

    // Behavioural model: running flag, current level and cycles left in phase.
    bit          m_run, m_lvl, m_tick, m_prev;
    int unsigned m_left, m_div;
    bit          ln [0:2];

    always #5 fastclk = ~fastclk;

    clkdiv_prog #(.W(W)) dut (
        .fastclk (fastclk),
        .nreset  (nreset),
        .div     (div),
        .mode    (mode),
        .step    (step),
        .clk     (clk),
        .tick    (tick),
        .halted  (halted)
    );

    task automatic chk(input string tag, input logic act, input logic exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, act, exp);
        end
    endtask

    task automatic m_start();
        m_div  = (div == '0) ? 1 : int'(div);
        m_run  = 1'b1;
        m_lvl  = 1'b1;
        m_left = m_div - 1;
        m_tick = 1'b1;
    endtask

    task automatic model_edge();
        bit seen, rise;
        if (!nreset) begin
            m_run = 0; m_lvl = 0; m_left = 0; m_tick = 0; m_prev = 0;
            ln[1] = 0; ln[2] = 0;
            return;
        end
        ln[0] = step;
        seen  = ln[DLY];
        ln[2] = ln[1];
        ln[1] = ln[0];
        rise   = seen && !m_prev;
        m_prev = seen;
        m_tick = 1'b0;
        if (!m_run) begin
            if (mode == 2'b00 || (mode == 2'b10 && rise)) m_start();
        end else if (m_lvl) begin
            if (m_left == 0) begin m_lvl = 0; m_left = m_div - 1; end
            else m_left--;
        end else begin
            if (mode == 2'b01 || mode == 2'b11) m_run = 0;
            else if (m_left == 0) begin
                if (mode == 2'b00) m_start();
                else m_run = 0;
            end else m_left--;
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge fastclk);
            model_edge();
            #1;
            chk("clk",    clk,    m_run && m_lvl);
            chk("tick",   tick,   m_tick);
            chk("halted", halted, !m_run);
        end
    endtask

    task automatic wait_tick(input string tag);
        bit got;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            cyc(1);
            if (tick === 1'b1) got = 1;
        end
        chk(tag, got, 1'b1);
    endtask

    bit pat [12] = '{1,1,0,0,0,1,1,1,0,0,0,1};

    initial begin
        // Reset held for three cycles with RUN / div=3 applied.
        nreset = 0; mode = 2'b00; div = W'(3);
        cyc(3);
        chk("rst_clk", clk, 1'b0);
        chk("rst_halted", halted, 1'b1);
        chk("rst_tick", tick, 1'b0);
        nreset = 1;
        cyc(1);
        chk("first_clk", clk, 1'b1);
        chk("first_tick", tick, 1'b1);
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            chk("run3_pat", clk, pat[i]);
        end

        // div=0 behaves as div=1.
        div = '0;
        cyc(10);

        // Divisor change mid high phase applies to the next period.
        div = W'(4);
        wait_tick("tmo_div4");
        cyc(1);
        div = W'(2);
        cyc(14);

        // HALT during HIGH: high phase completes, then IDLE.
        div = W'(5);
        wait_tick("tmo_div5");
        cyc(1);
        mode = 2'b01;
        cyc(8);
        chk("halt_high_idle", halted, 1'b1);

        // HALT during LOW: IDLE at the next edge.
        mode = 2'b00;
        wait_tick("tmo_halt_low");
        cyc(6);
        mode = 2'b01;
        cyc(1);
        chk("halt_low_idle", halted, 1'b1);
        chk("halt_low_clk", clk, 1'b0);

        // Single step, with a second pulse inside the period.
        mode = 2'b10; div = W'(2);
        cyc(3);
        step = 1;
        cyc(1);
        step = 0;
        cyc(DLY);
        chk("step_lat", clk, 1'b1);
        cyc(1);
        step = 1;
        cyc(1);
        step = 0;
        cyc(8);
        chk("step_done", halted, 1'b1);

        // Reset during HIGH truncates the phase.
        mode = 2'b00; div = W'(6);
        wait_tick("tmo_rst_high");
        cyc(1);
        nreset = 0;
        cyc(1);
        chk("rst_high_clk", clk, 1'b0);
        chk("rst_high_halted", halted, 1'b1);
        nreset = 1;

        // Randomized mix of modes, divisors, step pulses and resets.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 14) == 0) div  = W'($urandom_range(0, 6));
            step   = ($urandom_range(0, 3) == 0);
            nreset = ($urandom_range(0, 149) != 0);
            cyc(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clkdiv_prog.md
Name: clkdiv_prog

Overview:
- Runtime-programmable slow-clock generator for the picoMIPS core; replaces the fixed power-of-two divider.
- Derives clk from fastclk with a programmable half-period.
- Supports RUN, HALT and single-STEP modes for board-level debug.
- Emits a one-fastclk-cycle tick aligned with each clk rising edge, for logic that stays in the fastclk domain.

Parameters:
- W, 20, width of divisor input and internal phase counter.
- RST_DIV, 2**(W-1), divisor value loaded into div_q at reset.

Ports:
- fastclk  in  1  board clock; all state updates on its rising edge.
- nreset  in  1  synchronous, active-low reset, sampled on fastclk rising edge.
- div  in  W  half-period in fastclk cycles; 0 is treated as 1.
- mode  in  2  00 RUN, 01 HALT, 10 STEP, 11 treated as HALT.
- step  in  1  step request (push button); rising edge detected internally.
- clk  out  1  divided clock, registered, glitch-free.
- tick  out  1  high for exactly the first fastclk cycle of each clk high phase.
- halted  out  1  high while in IDLE (clk parked low).

Behaviour:
- Reset (nreset=0 at a fastclk edge): state=IDLE, clk=0, tick=0, halted=1, cnt=0, div_q=RST_DIV, step edge-detect register=0. Reset mid-period truncates the current phase immediately.
- States:
  - IDLE: clk=0, cnt held at 0.
  - HIGH: clk=1.
  - LOW: clk=0.
- clk = (state==HIGH), registered. halted = (state==IDLE), registered.
- Period start:
  - Every entry into HIGH latches div_q = (div==0 ? 1 : div), clears cnt and asserts tick for that one cycle.
  - div changes mid-period take effect at the next period start only.
- Phase end: a phase ends when cnt==div_q-1. Otherwise cnt increments by 1. Each phase therefore lasts exactly div_q fastclk cycles; period = 2*div_q; duty cycle 50%.
- IDLE transitions:
  - mode RUN -> HIGH at the next edge.
  - mode STEP with a step rising edge -> HIGH.
  - Otherwise remain in IDLE.
- HIGH at phase end -> LOW, regardless of mode. A high phase is never truncated except by reset.
- LOW transitions:
  - At phase end: mode RUN -> HIGH; any other mode -> IDLE.
  - mode HALT before phase end -> IDLE at the next edge (low phase cut short; clk stays 0, so no glitch).
  - mode STEP before phase end: continue the LOW phase, then -> IDLE. A single step therefore produces exactly one full period.
- Step edge-detect:
  - step_prev is updated every cycle.
  - A step edge is consumed only in IDLE with mode STEP.
  - Edges arriving in HIGH/LOW, or in other modes, are discarded (not queued).
- Mode changes mid-period never produce a clk pulse shorter than div_q cycles.
- Counter width: cnt is W bits. div_q=2**W-1 is legal; no wrap occurs because cnt clears at div_q-1.

Optional Feature:
- Macro: CLKDIV_STEP_SYNC_EN.
- Defined: step passes through a 2-flop synchroniser (reset to 0) before edge detection. Step-to-HIGH latency is 3 fastclk edges from the step assertion edge.
- Undefined: step is edge-detected directly, latency 1 edge. The caller guarantees step is synchronous to fastclk.

Decomposition:
- Package clkdiv_pkg holds:
  - typedef enum logic [1:0] {IDLE, HIGH, LOW} clkdiv_state_t;
  - typedef enum logic [1:0] mode_t with MODE_RUN=2'b00, MODE_HALT=2'b01, MODE_STEP=2'b10;
- One sub-module: clkdiv_edge_det (optional synchroniser plus rising-edge detector for step), instantiated once.

Test Plan:
- Reset held for 3 cycles, then mode=RUN, div=3 -> clk=0, halted=1 during reset. First edge after release: clk=1, tick=1. Then clk pattern 1,1,1,0,0,0 repeating; tick exactly once per 6 cycles.
- RUN, div=0 -> behaves as div=1: clk toggles every fastclk cycle; tick on every clk high cycle.
- RUN, div=4, div changed to 2 in the 2nd cycle of a high phase -> current period stays 4 high + 4 low; next period 2+2.
- RUN, div=5, mode=HALT asserted during cycle 2 of HIGH -> high phase completes all 5 cycles, then IDLE (clk=0, halted=1) with no low phase counted. HALT asserted during LOW -> IDLE at the next edge.
- mode=STEP, div=2, step pulsed once (CLKDIV_STEP_SYNC_EN undefined) -> exactly one period, clk 1,1,0,0, then IDLE. A second step pulse during that period produces no additional period.
- With CLKDIV_STEP_SYNC_EN defined, same stimulus -> clk rises 3 edges after step assertion; nreset=0 during HIGH -> clk=0 and halted=1 at the next edge.
